// File: rtl/md_sequencer_if.sv
// Handshake bundle between the EX/ID stages and the multiply/divide sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface md_sequencer_if;
    logic        E_start_mult;
    logic        E_start_div;
    logic        E_md_signal;
    logic [2:0]  E_md_control;
    logic [31:0] E_Qa;
    logic [31:0] E_Qb;
    logic        ID_md_use;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    modport master (
        output E_start_mult, E_start_div, E_md_signal, E_md_control, E_Qa, E_Qb, ID_md_use,
        input  md_busy, md_stall, HI, LO, md_out
    );

    modport slave (
        input  E_start_mult, E_start_div, E_md_signal, E_md_control, E_Qa, E_Qb, ID_md_use,
        output md_busy, md_stall, HI, LO, md_out
    );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency multiply/divide sequencer that owns HI/LO and stalls the front end
// while a HI/LO-dependent instruction would otherwise see a stale result.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    md_sequencer_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic { IDLE, RUN } state_e;
    typedef enum logic { OP_MULT, OP_DIV } op_e;

    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    op_e                op;
    logic [31:0]        op_a, op_b;
    logic               op_signed;
    logic [31:0]        hi, lo;

    logic               start_mult, start_div, start_any;
    logic               load, commit;
    logic [63:0]        product;
    logic signed [32:0] div_a, div_b, quot, rem;

    // Mult has priority when both starts arrive together.
    assign start_mult = md.E_start_mult;
    assign start_div  = md.E_start_div & ~md.E_start_mult;
    assign start_any  = start_mult | start_div;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start_any) begin
                    load       = 1'b1;
                    state_next = RUN;
                    cnt_next   = start_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Extending by the sign (or zero) bit lets one 64-bit multiply serve both signednesses.
    always_comb begin
        product = {{32{op_signed & op_a[31]}}, op_a} * {{32{op_signed & op_b[31]}}, op_b};
    end

    // 33-bit signed division keeps 0x80000000 / -1 in range; truncating back gives 0x80000000.
    always_comb begin
        div_a = {op_signed & op_a[31], op_a};
        div_b = {op_signed & op_b[31], op_b};
        quot  = '0;
        rem   = '0;
        if (op_b != 32'd0) begin
            quot = div_a / div_b;
            rem  = div_a % div_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= OP_MULT;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                op        <= start_mult ? OP_MULT : OP_DIV;
                op_a      <= md.E_Qa;
                op_b      <= md.E_Qb;
                op_signed <= md.E_md_signal;
            end
            if (commit) begin
                if (op == OP_MULT) begin
                    hi <= product[63:32];
                    lo <= product[31:0];
                end else if (op_b != 32'd0) begin
                    hi <= rem[31:0];
                    lo <= quot[31:0];
                end
            end else if (state == IDLE && !start_any) begin
                case (md.E_md_control)
                    3'b001:  hi <= md.E_Qa;
                    3'b010:  lo <= md.E_Qa;
                    default: ;
                endcase
            end
        end
    end

    assign md.md_busy  = (state == RUN);
    assign md.md_stall = md.ID_md_use & ((state == RUN) | md.E_start_mult | md.E_start_div);
    assign md.HI       = hi;
    assign md.LO       = lo;

    always_comb begin
        case (md.E_md_control)
            3'b011:  md.md_out = hi;
            3'b100:  md.md_out = lo;
            default: md.md_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_md_sequencer.sv
// Randomised and directed bench for md_sequencer, checked every cycle against
// an arithmetic model of HI/LO, busy and stall.
module tb_md_sequencer;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    md_sequencer_if bus ();

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .md    (bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_left = 0;
    bit          m_write = 1'b0;
    logic [63:0] m_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result as {HI,LO}, worked out with 64-bit integer arithmetic.
    function automatic logic [63:0] model_result(input bit is_mult, input bit sg,
                                                 input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        if (is_mult) return sa * sb;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_write) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
        end else if (bus.E_start_mult || bus.E_start_div) begin
            m_left  <= bus.E_start_mult ? MULT_N : DIV_N;
            m_write <= bus.E_start_mult || (bus.E_Qb != 32'd0);
            if (bus.E_start_mult || bus.E_Qb != 32'd0)
                m_res <= model_result(bus.E_start_mult, bus.E_md_signal, bus.E_Qa, bus.E_Qb);
        end else if (bus.E_md_control == 3'd1) begin
            m_hi <= bus.E_Qa;
        end else if (bus.E_md_control == 3'd2) begin
            m_lo <= bus.E_Qa;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en && Reset) begin
            check("busy", {31'd0, bus.md_busy}, {31'd0, m_left > 0});
            check("stall", {31'd0, bus.md_stall},
                  {31'd0, bus.ID_md_use & ((m_left > 0) | bus.E_start_mult | bus.E_start_div)});
            check("HI", bus.HI, m_hi);
            check("LO", bus.LO, m_lo);
            check("md_out", bus.md_out, (bus.E_md_control == 3'd3) ? m_hi :
                                        (bus.E_md_control == 3'd4) ? m_lo : 32'd0);
        end
    end

    task automatic drive(input bit sm, input bit sd, input bit sg, input logic [2:0] ctrl,
                         input logic [31:0] qa, input logic [31:0] qb, input bit use_md);
        bus.E_start_mult = sm;
        bus.E_start_div  = sd;
        bus.E_md_signal  = sg;
        bus.E_md_control = ctrl;
        bus.E_Qa         = qa;
        bus.E_Qb         = qb;
        bus.ID_md_use    = use_md;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issues one op and checks the busy window length; operands are scrambled during RUN.
    task automatic run_op(input string name, input bit sm, input bit sd, input bit sg,
                          input logic [31:0] qa, input logic [31:0] qb, input int exp_n);
        int n;
        drive(sm, sd, sg, 3'd0, qa, qb, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 32'h13579BDF, 1'b0);
        n = 0;
        while (bus.md_busy && n < 50) begin
            tick();
            n++;
        end
        check({name, "_busy_cycles"}, n, exp_n);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, stalls;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        check("reset_HI", bus.HI, 32'd0);
        check("reset_LO", bus.LO, 32'd0);
        check("reset_busy", {31'd0, bus.md_busy}, 32'd0);
        Reset = 1'b1;
        cmp_en = 1'b1;
        tick();

        run_op("smult", 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3, MULT_N);
        check("smult_HI", bus.HI, 32'hFFFFFFFF);
        check("smult_LO", bus.LO, 32'hFFFFFFFA);

        run_op("udiv", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7, DIV_N);
        check("udiv_LO", bus.LO, 32'd14);
        check("udiv_HI", bus.HI, 32'd2);

        run_op("sdiv", 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, DIV_N);
        check("sdiv_LO", bus.LO, 32'hFFFFFFFD);
        check("sdiv_HI", bus.HI, 32'hFFFFFFFF);

        run_op("sdiv_ovf", 1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, DIV_N);
        check("sdiv_ovf_LO", bus.LO, 32'h80000000);
        check("sdiv_ovf_HI", bus.HI, 32'd0);

        drive(1'b0, 1'b0, 1'b0, 3'd1, 32'h1234, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd2, 32'h5678, 32'd0, 1'b0);
        tick();
        run_op("div0", 1'b0, 1'b1, 1'b1, 32'd55, 32'd0, DIV_N);
        check("div0_HI", bus.HI, 32'h1234);
        check("div0_LO", bus.LO, 32'h5678);

        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd3, 32'd5, 1'b1);
        #1;
        check("stall_start", {31'd0, bus.md_stall}, 32'd1);
        @(posedge Clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        n = 0;
        stalls = 0;
        while (bus.md_busy && n < 50) begin
            if (bus.md_stall) stalls++;
            tick();
            n++;
        end
        check("stall_busy_cycles", n, MULT_N);
        check("stall_cycles", stalls, MULT_N);
        check("stall_after", {31'd0, bus.md_stall}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd4, 32'd0, 32'd0, 1'b1);
        #1;
        check("mflo_out", bus.md_out, 32'd15);
        tick();

        run_op("both", 1'b1, 1'b1, 1'b0, 32'd6, 32'd7, MULT_N);
        check("both_LO", bus.LO, 32'd42);
        check("both_HI", bus.HI, 32'd0);

        drive(1'b0, 1'b1, 1'b1, 3'd0, 32'd100, 32'd7, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) tick();
        Reset = 1'b0;
        #1;
        check("midrst_HI", bus.HI, 32'd0);
        check("midrst_LO", bus.LO, 32'd0);
        check("midrst_busy", {31'd0, bus.md_busy}, 32'd0);
        Reset = 1'b1;
        tick();
        run_op("post_rst", 1'b1, 1'b0, 1'b1, 32'd6, 32'd7, MULT_N);
        check("post_rst_LO", bus.LO, 32'd42);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
                  3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom));
            tick();
        end

        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (bus.md_busy && n < 50) begin
            tick();
            n++;
        end
        check("drain_idle", {31'd0, bus.md_busy}, 32'd0);
        tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
